piso_serializer: RTL

Parametrised parallel-in/serial-out shifter for the UART transmit path, generalising the 8-bit LSB-first serializer. It accepts a WIDTH-bit word over a valid/ready handshake, shifts it out one bit per bit-rate tick in either bit order, and reports completion with a one-cycle done pulse. It sits between the TX holding logic and the frame builder (start/parity/stop), which supplies the bit-rate `enable` tick.

---
 rtl/piso_serializer.sv | 92 +++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter for the UART TX path: accepts a WIDTH-bit word over
// valid/ready and emits it one bit per enable tick, LSB- or MSB-first, then pulses done.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             enable,
  output logic             data_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] shreg_shifted;
  logic             head_bit;

  // The output end of the register and the shift direction follow the bit order.
  generate
    if (MSB_FIRST) begin : g_msb
      assign head_bit      = shreg_q[WIDTH-1];
      assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign head_bit      = shreg_q[0];
      assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          shreg_d = data_in;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (enable) begin
          if (cnt_q == LAST_BIT) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
            shreg_d = '0;
          end else begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign data_ready = (state_q == S_IDLE);
  assign busy       = (state_q == S_SHIFT);
  assign data_out   = busy & head_bit;
  assign done       = done_q;

endmodule
